// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions for the decimal datapath.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    function automatic bcd_digit_t nines(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_addsub_pipe_if.sv
// Operand/result handshake bundle for bcd_addsub_pipe.
interface bcd_addsub_pipe_if #(parameter int DIGITS = 5);
    import bcd_pkg::*;

    localparam int W = BCD_DIGIT_W * DIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_err;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_err
    );

endinterface

// File: rtl/bcd_digit_cell.sv
// Combinational one-digit BCD adder with decimal-adjust.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);

    logic [BCD_DIGIT_W:0] bin;

    always_comb begin
        bin  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        cout = (bin > {1'b0, BCD_MAX});
        s    = cout ? (bin[BCD_DIGIT_W-1:0] + BCD_CORR) : bin[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_addsub_pipe.sv
// Carry-skewed pipelined N-digit packed-BCD adder/subtractor.
// Optional invalid-digit flag is built only when BCD_DIGIT_CHECK_EN is defined.
module bcd_addsub_pipe
    import bcd_pkg::*;
#(
    parameter int DIGITS           = 5,
    parameter int DIGITS_PER_STAGE = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    bcd_addsub_pipe_if.slave   bus
);

    localparam int W      = BCD_DIGIT_W * DIGITS;
    localparam int STAGES = (DIGITS + DIGITS_PER_STAGE - 1) / DIGITS_PER_STAGE;

    logic              adv;
    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] c_r;
    logic [W-1:0]      a_r   [STAGES];
    logic [W-1:0]      b_r   [STAGES];
    logic [W-1:0]      s_r   [STAGES];

    logic [W-1:0]      b_eff;
    logic [W-1:0]      src_a [STAGES];
    logic [W-1:0]      src_b [STAGES];
    logic [W-1:0]      src_s [STAGES];
    logic [W-1:0]      nxt_s [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] grp_c;

    logic [DIGITS-1:0] dcin;
    logic [DIGITS-1:0] cc;
    bcd_digit_t        ds    [DIGITS];

    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    // Subtraction is folded in at entry: nines-complement B and force carry-in.
    always_comb begin
        b_eff = bus.in_b;
        if (bus.in_sub) begin
            for (int i = 0; i < DIGITS; i++)
                b_eff[i*BCD_DIGIT_W +: BCD_DIGIT_W] = nines(bus.in_b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    always_comb begin
        src_a[0] = bus.in_a;
        src_b[0] = b_eff;
        src_s[0] = '0;
        src_c[0] = bus.in_sub ? 1'b1 : bus.in_cin;
        src_v[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_r[k-1];
            src_b[k] = b_r[k-1];
            src_s[k] = s_r[k-1];
            src_c[k] = c_r[k-1];
            src_v[k] = vld_r[k-1];
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_cell
        localparam int G = i / DIGITS_PER_STAGE;
        if (i % DIGITS_PER_STAGE == 0) begin : g_head
            assign dcin[i] = src_c[G];
        end else begin : g_chain
            assign dcin[i] = cc[i-1];
        end
        bcd_digit_cell u_cell (
            .a    (src_a[G][i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .b    (src_b[G][i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin  (dcin[i]),
            .s    (ds[i]),
            .cout (cc[i])
        );
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_grp
        localparam int LAST = ((g + 1) * DIGITS_PER_STAGE < DIGITS)
                              ? (g + 1) * DIGITS_PER_STAGE - 1 : DIGITS - 1;
        assign grp_c[g] = cc[LAST];
    end

    // Each stage splices its freshly resolved digits into the running sum.
    always_comb begin
        for (int g = 0; g < STAGES; g++) begin
            nxt_s[g] = src_s[g];
            for (int i = 0; i < DIGITS; i++) begin
                if (i / DIGITS_PER_STAGE == g)
                    nxt_s[g][i*BCD_DIGIT_W +: BCD_DIGIT_W] = ds[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            c_r   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else if (adv) begin
            vld_r <= src_v;
            c_r   <= grp_c;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= src_a[k];
                b_r[k] <= src_b[k];
                s_r[k] <= nxt_s[k];
            end
        end
    end

    assign bus.out_valid = vld_r[STAGES-1];
    assign bus.out_sum   = s_r[STAGES-1];
    assign bus.out_cout  = c_r[STAGES-1];

`ifdef BCD_DIGIT_CHECK_EN
    logic              in_err;
    logic [STAGES-1:0] e_r;

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((bus.in_a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) ||
                (bus.in_b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX))
                in_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_r <= '0;
        end else if (adv) begin
            e_r[0] <= in_err;
            for (int k = 1; k < STAGES; k++)
                e_r[k] <= e_r[k-1];
        end
    end

    assign bus.out_err = e_r[STAGES-1];
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_pipe.sv
// Directed-vector bench for bcd_addsub_pipe (DIGITS=5, one digit per stage).
module tb_bcd_addsub_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    bcd_addsub_pipe_if #(.DIGITS(5)) bus ();

    bcd_addsub_pipe #(.DIGITS(5), .DIGITS_PER_STAGE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] rep(input int d);
        logic [3:0] dd;
        dd = d[3:0];
        return {5{dd}};
    endfunction

    task automatic run_one(input logic [19:0] a, input logic [19:0] b, input logic sub,
                           input logic cin, input logic [19:0] es, input logic ec,
                           input string tag);
        int lat;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        bus.in_cin    = cin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 5);
        check({tag, "_sum"}, bus.out_sum, es);
        check({tag, "_cout"}, bus.out_cout, ec);
        tick();
    endtask

    initial begin
        logic [19:0] exp_q [$];
        logic [19:0] e;
        logic [19:0] held;
        logic        acc;
        logic        hs;
        logic        stale;
        logic        exp_err;
        logic [2:0]  errs;
        int          idx;
        int          rcv;
        int          first_c;
        int          last_c;

        checks = 0;
        fails  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_sum", bus.out_sum, 0);
        check("rst_cout", bus.out_cout, 0);
        check("rst_err", bus.out_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();

        run_one(20'h99999, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, "add_wrap");
        run_one(20'h12345, 20'h00345, 1'b1, 1'b0, 20'h12000, 1'b1, "sub_pos");
        run_one(20'h00001, 20'h00002, 1'b1, 1'b0, 20'h99999, 1'b0, "sub_neg");
        run_one(20'h12345, 20'h11111, 1'b0, 1'b1, 20'h23457, 1'b0, "add_cin");
        run_one(20'h50000, 20'h50000, 1'b0, 1'b0, 20'h00000, 1'b1, "add_top");
        run_one(20'h00500, 20'h00500, 1'b1, 1'b1, 20'h00000, 1'b1, "sub_eq");
        run_one(20'h04876, 20'h05129, 1'b0, 1'b0, 20'h10005, 1'b0, "add_ripple");

        // Back-to-back 8 beats, downstream always ready.
        exp_q.delete();
        rcv = 0; first_c = -1; last_c = -1;
        bus.out_ready = 1'b1;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c < 8) begin
                bus.in_valid = 1'b1;
                bus.in_a     = rep(c);
                bus.in_b     = 20'h00001;
                e = rep(c);
                e[3:0] = 4'(c + 1);
                exp_q.push_back(e);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (bus.out_valid) begin
                if (rcv < 8) check("b2b_sum", bus.out_sum, exp_q[rcv]);
                if (first_c < 0) first_c = c;
                last_c = c;
                rcv++;
            end
        end
        check("b2b_count", rcv, 8);
        check("b2b_span", last_c - first_c, 7);

        // Fill with downstream stalled, hold, then release and drain.
        exp_q.delete();
        idx = 0; rcv = 0; held = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.out_ready = (c >= 9);
            bus.in_valid  = (idx < 9);
            bus.in_a      = rep(idx);
            bus.in_b      = rep(1);
            #0;
            if (c == 5) held = bus.out_sum;
            if (c >= 6 && c <= 8) begin
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_valid", bus.out_valid, 1);
                check("stall_sum", bus.out_sum, held);
            end
            acc = bus.in_valid & bus.in_ready;
            hs  = bus.out_valid & bus.out_ready;
            e   = bus.out_sum;
            tick();
            if (acc) idx++;
            if (hs) begin
                if (rcv < 9) check("stall_order", e, rep(rcv + 1));
                rcv++;
            end
        end
        bus.in_valid = 1'b0;
        check("stall_sent", idx, 9);
        check("stall_recv", rcv, 9);

        // Reset with beats in flight.
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = rep(c);
            bus.in_b     = 20'h00000;
            tick();
        end
        bus.in_valid = 1'b0;
        check("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_sum", bus.out_sum, 0);
        tick();
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.out_valid) stale = 1'b1;
        end
        check("no_stale", stale, 0);
        check("post_rst_in_ready", bus.in_ready, 1);

        // Invalid digit flag travels with its own beat only.
`ifdef BCD_DIGIT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        exp_q.delete();
        exp_q.push_back(20'h00001);
        exp_q.push_back(20'h0000A);
        exp_q.push_back(20'h00002);
        rcv = 0; errs = '0;
        for (int c = 0; c < 15; c++) begin
            bus.in_valid = (c < 3);
            bus.in_a     = (c < 3) ? exp_q[c] : 20'h0;
            bus.in_b     = 20'h00001;
            tick();
            if (bus.out_valid && rcv < 3) begin
                errs[rcv] = bus.out_err;
                if (rcv == 0) check("err_nb0_sum", bus.out_sum, 20'h00002);
                if (rcv == 2) check("err_nb2_sum", bus.out_sum, 20'h00003);
                rcv++;
            end
        end
        check("err_count", rcv, 3);
        check("err_nb0", errs[0], 0);
        check("err_bad", errs[1], exp_err);
        check("err_nb2", errs[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
